serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial ripple adder: accepts two WIDTH-bit operands one bit per accepted beat, LSB first, and produces the sum serially and as an assembled word with carry-out. It is the additive counterpart of the combinational half/full subtractor blocks in the arithmetic library. Its bit-serial operand interface pairs with the serial subtractor datapath and is reused by the sequential-circuits exercises.

## Interface
- WIDTH, 8: operand/sum width in bits, ≥2.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a new addition; honoured only in IDLE.
- bit_valid  input  1  a_bit/b_bit carry a valid operand bit this cycle.
- a_bit  input  1  operand A bit, LSB first.
- b_bit  input  1  operand B bit, LSB first.
- busy  output  1  high in RUN.
- sum_bit  output  1  registered sum bit for the last accepted beat.
- sum_valid  output  1  one-cycle strobe qualifying sum_bit.
- sum_word  output  WIDTH  assembled sum; valid from done until next start.
- cout  output  1  final carry-out; valid with sum_word.
- done  output  1  one-cycle strobe: addition complete.
- ovf  output  1  signed overflow; present only with SERIAL_ADDER_OVF_EN.

## Operation
- FSM states: IDLE, RUN, DONE. Encoding is free.
- IDLE: start=1 → RUN next cycle. Entering RUN clears carry and bit counter (width clog2(WIDTH+1)) and clears sum_word to 0. bit_valid in IDLE is ignored.
- RUN: each cycle with bit_valid=1 is one beat:
  - s = a_bit ^ b_bit ^ c
  - c_next = (a_bit & b_bit) | (c & (a_bit ^ b_bit))
  - sum_bit <= s and sum_valid <= 1.
  - sum_word shifts right with s inserted at bit WIDTH-1, so after WIDTH beats bit 0 holds the LSB.
  - The counter increments.
- RUN, cycles with bit_valid=0: no state change and sum_valid=0. Gaps of any length are allowed.
- RUN: the beat that makes counter == WIDTH → DONE. That same edge loads cout with c_next.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- start while in RUN or DONE is ignored and has no effect.
- sum_word and cout hold their values in IDLE until the next start is accepted.

## Timing
- Reset values: every output is 0 (busy, sum_bit, sum_valid, sum_word, cout, done, ovf); FSM is IDLE; carry and counter are 0.
- rst has priority over all inputs. Asserting it mid-RUN aborts the operation, and the next cycle is IDLE with all outputs 0.
- Latency: start at edge n → busy=1 from edge n+1. The first beat can be accepted at edge n+1.
- Each beat accepted at edge k → sum_bit/sum_valid visible after edge k; exactly one cycle of sum_valid per beat.
- Last beat accepted at edge k → DONE after edge k. After that edge, done=1 and sum_word/cout are final; busy=0.
- Minimum operation: 1 start cycle + WIDTH beat cycles + 1 DONE cycle. Back-to-back: start is accepted in the IDLE cycle immediately after DONE.
- Arithmetic: sum_word = (A + B) mod 2^WIDTH and cout = bit WIDTH of A + B, both unsigned.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - ovf port and logic exist.
  - On the final beat, ovf <= (a_bit == b_bit) && (s != a_bit), i.e. two's-complement overflow.
  - ovf is valid with done and holds like cout.
  - ovf is cleared on accepted start and on rst.
- Not defined: the ovf port is absent and no overflow logic is built. All other behaviour is identical.

## Test plan
- Reset: rst for 2 cycles, with start/bit_valid toggling → all outputs 0, busy=0, no done.
- WIDTH=8, A=0x35, B=0x4A, contiguous beats → 8 sum_valid strobes with bits 1,1,1,1,1,1,1,0 (LSB first); done; sum_word=0x7F, cout=0.
- A=0xFF, B=0x01, with bit_valid deasserted for 3 cycles after beats 2 and 5 → sum_word=0x00, cout=1. done arrives exactly 1 cycle after the 8th accepted beat; no sum_valid during gaps.
- OVF_EN defined, A=0x7F, B=0x01 → sum_word=0x80, cout=0, ovf=1. Then A=0x80, B=0x80 → sum_word=0x00, cout=1, ovf=1. Then A=0x10, B=0x20 → ovf=0.
- start pulsed on beat 4 of an operation (A=0x0F, B=0x01) → ignored; result sum_word=0x10 after 8 beats.
- rst asserted after 5 beats → next cycle IDLE, outputs 0. A fresh start with A=0x03, B=0x05 → sum_word=0x08, cout=0. Back-to-back start immediately after done is accepted.

Source files
------------

// File: rtl/serial_adder_if.sv
// ---------------------------------------------------------------------------
// serial_adder_if : operand/result bundle for serial_adder (master = driver)
// Revision 1.0 ; ovf only when SERIAL_ADDER_OVF_EN is defined
// ---------------------------------------------------------------------------
`default_nettype none

interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             bit_valid;
  logic             a_bit;
  logic             b_bit;
  logic             busy;
  logic             sum_bit;
  logic             sum_valid;
  logic [WIDTH-1:0] sum_word;
  logic             cout;
  logic             done;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  busy, sum_bit, sum_valid, sum_word, cout, done, ovf
  );
  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output busy, sum_bit, sum_valid, sum_word, cout, done, ovf
  );
`else
  modport master (
    output start, bit_valid, a_bit, b_bit,
    input  busy, sum_bit, sum_valid, sum_word, cout, done
  );
  modport slave (
    input  start, bit_valid, a_bit, b_bit,
    output busy, sum_bit, sum_valid, sum_word, cout, done
  );
`endif
endinterface

`default_nettype wire

// File: rtl/serial_adder.sv
// ---------------------------------------------------------------------------
// serial_adder : bit-serial LSB-first ripple adder, serial and word result
// Revision 1.0 ; signed overflow output enabled by SERIAL_ADDER_OVF_EN
// ---------------------------------------------------------------------------
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  wire            clk,
  input  wire            rst,
  serial_adder_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             sum_bit_q;
  logic             sum_valid_q;
  logic [WIDTH-1:0] sum_word_q;
  logic             cout_q;
  logic             done_q;

  logic             sum_d;
  logic             carry_d;

  assign sum_d   = bus.a_bit ^ bus.b_bit ^ carry_q;
  assign carry_d = (bus.a_bit & bus.b_bit) | (carry_q & (bus.a_bit ^ bus.b_bit));

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;
  logic ovf_d;
  // Overflow: operands agree in sign but the sign of the sum differs.
  assign ovf_d   = (bus.a_bit == bus.b_bit) && (sum_d != bus.a_bit);
  assign bus.ovf = ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      sum_bit_q   <= 1'b0;
      sum_valid_q <= 1'b0;
      sum_word_q  <= '0;
      cout_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      sum_valid_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q    <= S_RUN;
            busy_q     <= 1'b1;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            sum_word_q <= '0;
            cout_q     <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q      <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (bus.bit_valid) begin
            sum_bit_q   <= sum_d;
            sum_valid_q <= 1'b1;
            sum_word_q  <= {sum_d, sum_word_q[WIDTH-1:1]};
            carry_q     <= carry_d;
            cnt_q       <= cnt_q + 1'b1;
            if (cnt_q == LAST_BEAT) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              cout_q  <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
              ovf_q   <= ovf_d;
`endif
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.sum_bit   = sum_bit_q;
  assign bus.sum_valid = sum_valid_q;
  assign bus.sum_word  = sum_word_q;
  assign bus.cout      = cout_q;
  assign bus.done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_adder : directed table-driven bench for serial_adder (WIDTH=8)
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_adder;

  localparam int WIDTH = 8;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         gap_len;     // idle cycles inserted after beats 2 and 5
    int         start_beat;  // beat (1-based) on which start is re-pulsed, 0 = none
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(WIDTH)) bus();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      bus.busy,      0);
    check({tag, "_sum_bit"},   bus.sum_bit,   0);
    check({tag, "_sum_valid"}, bus.sum_valid, 0);
    check({tag, "_sum_word"},  bus.sum_word,  0);
    check({tag, "_cout"},      bus.cout,      0);
    check({tag, "_done"},      bus.done,      0);
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, "_ovf"},       bus.ovf,       0);
`endif
  endtask

  // One start cycle, WIDTH beats (optionally with gaps), then the done cycle
  // and the following IDLE cycle. Leaves the DUT ready for a back-to-back start.
  task automatic run_op(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    bus.start = 1'b1; bus.bit_valid = 1'b0;
    tick();
    bus.start = 1'b0;
    check({t, "_busy_after_start"}, bus.busy, 1);
    check({t, "_sum_word_cleared"}, bus.sum_word, 0);
    for (int i = 0; i < WIDTH; i++) begin
      bus.a_bit = v.a[i]; bus.b_bit = v.b[i]; bus.bit_valid = 1'b1;
      bus.start = (i + 1 == v.start_beat);
      tick();
      bus.bit_valid = 1'b0; bus.start = 1'b0;
      check($sformatf("%s_beat%0d_valid", t, i), bus.sum_valid, 1);
      check($sformatf("%s_beat%0d_bit", t, i), bus.sum_bit, v.sum[i]);
      if (i < WIDTH - 1) begin
        check($sformatf("%s_beat%0d_done", t, i), bus.done, 0);
        check($sformatf("%s_beat%0d_busy", t, i), bus.busy, 1);
      end
      if ((i == 1 || i == 4) && v.gap_len > 0) begin
        for (int g = 0; g < v.gap_len; g++) begin
          bus.a_bit = 1'b1; bus.b_bit = 1'b1;
          tick();
          check($sformatf("%s_gap%0d_%0d_valid", t, i, g), bus.sum_valid, 0);
          check($sformatf("%s_gap%0d_%0d_done", t, i, g), bus.done, 0);
          check($sformatf("%s_gap%0d_%0d_busy", t, i, g), bus.busy, 1);
        end
      end
    end
    check({t, "_done"}, bus.done, 1);
    check({t, "_busy_at_done"}, bus.busy, 0);
    check({t, "_sum_word"}, bus.sum_word, v.sum);
    check({t, "_cout"}, bus.cout, v.cout);
`ifdef SERIAL_ADDER_OVF_EN
    check({t, "_ovf"}, bus.ovf, v.ovf);
`endif
    tick();
    check({t, "_done_one_cycle"}, bus.done, 0);
    check({t, "_idle_busy"}, bus.busy, 0);
    check({t, "_idle_valid"}, bus.sum_valid, 0);
    check({t, "_sum_word_hold"}, bus.sum_word, v.sum);
    check({t, "_cout_hold"}, bus.cout, v.cout);
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{a: 8'h35, b: 8'h4A, sum: 8'h7F, cout: 1'b0, ovf: 1'b0, gap_len: 0, start_beat: 0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, sum: 8'h00, cout: 1'b1, ovf: 1'b0, gap_len: 3, start_beat: 0};
    vecs[2] = '{a: 8'h7F, b: 8'h01, sum: 8'h80, cout: 1'b0, ovf: 1'b1, gap_len: 0, start_beat: 0};
    vecs[3] = '{a: 8'h80, b: 8'h80, sum: 8'h00, cout: 1'b1, ovf: 1'b1, gap_len: 0, start_beat: 0};
    vecs[4] = '{a: 8'h10, b: 8'h20, sum: 8'h30, cout: 1'b0, ovf: 1'b0, gap_len: 0, start_beat: 0};
    vecs[5] = '{a: 8'h0F, b: 8'h01, sum: 8'h10, cout: 1'b0, ovf: 1'b0, gap_len: 0, start_beat: 4};
    vecs[6] = '{a: 8'hC8, b: 8'h64, sum: 8'h2C, cout: 1'b1, ovf: 1'b0, gap_len: 1, start_beat: 2};

    bus.start = 1'b0; bus.bit_valid = 1'b0; bus.a_bit = 1'b0; bus.b_bit = 1'b0;
    rst = 1'b1;

    // Reset held two cycles while start/bit_valid toggle.
    bus.start = 1'b1; bus.bit_valid = 1'b1;
    tick();
    check_all_zero("rst_c1");
    bus.start = 1'b0; bus.bit_valid = 1'b0;
    tick();
    check_all_zero("rst_c2");
    rst = 1'b0;

    // bit_valid without start in IDLE does nothing.
    bus.bit_valid = 1'b1; bus.a_bit = 1'b1; bus.b_bit = 1'b0;
    tick();
    bus.bit_valid = 1'b0;
    check_all_zero("idle_ignore");

    // Abort mid-operation with reset after 5 beats of 0xFF + 0x00.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.a_bit = 1'b1; bus.b_bit = 1'b0; bus.bit_valid = 1'b1;
      tick();
    end
    bus.bit_valid = 1'b0;
    check("abort_partial_word", bus.sum_word, 32'hF8);
    check("abort_busy_before", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("abort");
    tick();
    check_all_zero("abort_idle");

    // Fresh operation after the abort, then the table back-to-back.
    run_op('{a: 8'h03, b: 8'h05, sum: 8'h08, cout: 1'b0, ovf: 1'b0, gap_len: 0, start_beat: 0}, 99);
    for (int k = 0; k < 7; k++) begin
      run_op(vecs[k], k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
